median_stream_filter: RTL

- Streaming 3x3 rank filter for raster images of parametrised size and pixel width.
- Replaces the standalone nine-input sorter and its testbench glue with a self-contained engine: line buffers, window assembly, a 3-stage pipelined rank network and frame bookkeeping.
- Sits between the pixel source and the result RAM writer, and drives that writer's data and done strobe directly.
- Selectable median, min or max output per frame.

---
 rtl/median_stream_filter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/median_stream_filter.sv
// Streaming 3x3 rank filter (median/min/max) with line buffers, raster bookkeeping
// and a three-register rank pipeline; accepted pixel in cycle N yields output in N+3.
module median_stream_filter #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pix,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_eol,
    output logic             done,
    output logic             sof_err
);
    localparam int AW = $clog2(IMG_W);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);

    typedef enum logic { IDLE, ACTIVE } state_t;
    typedef enum logic [1:0] { RANK_MED, RANK_MIN, RANK_MAX } rank_t;

    function automatic logic [PIX_W-1:0] min2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        return (a < b) ? a : b;
    endfunction
    function automatic logic [PIX_W-1:0] max2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        return (a < b) ? b : a;
    endfunction
    function automatic logic [PIX_W-1:0] min3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        return min2(min2(a, b), c);
    endfunction
    function automatic logic [PIX_W-1:0] max3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        return max2(max2(a, b), c);
    endfunction
    function automatic logic [PIX_W-1:0] med3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction
    function automatic rank_t decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return RANK_MIN;
            2'd2:    return RANK_MAX;
            default: return RANK_MED;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] row_q, row_d, col_q, col_d;
    rank_t            rank_q, rank_d;
    logic             sof_err_d;

    logic             acc, win_ok, eol_flag, last_flag;
    logic [CNT_W-1:0] cur_row, cur_col;
    rank_t            cur_rank;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        rank_d    = rank_q;
        sof_err_d = 1'b0;
        acc       = 1'b0;
        cur_row   = row_q;
        cur_col   = col_q;
        cur_rank  = rank_q;
        // An SOF pixel always restarts the frame at (0,0), abandoning any frame in progress.
        if (in_valid && in_sof) begin
            acc       = 1'b1;
            cur_row   = '0;
            cur_col   = '0;
            cur_rank  = decode_mode(mode);
            rank_d    = cur_rank;
            sof_err_d = (state_q == ACTIVE);
        end else if (in_valid && state_q == ACTIVE) begin
            acc = 1'b1;
        end
        if (acc) begin
            state_d = ACTIVE;
            if (cur_col == LAST_COL) begin
                col_d = '0;
                if (cur_row == LAST_ROW) begin
                    row_d   = '0;
                    state_d = IDLE;
                end else begin
                    row_d = cur_row + CNT_W'(1);
                end
            end else begin
                col_d = cur_col + CNT_W'(1);
                row_d = cur_row;
            end
        end
    end

    assign win_ok    = (cur_row >= CNT_W'(2)) && (cur_col >= CNT_W'(2));
    assign eol_flag  = (cur_col == LAST_COL);
    assign last_flag = eol_flag && (cur_row == LAST_ROW);

    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb2 [IMG_W];
    logic [AW-1:0]    col_idx;
    logic [PIX_W-1:0] up1, up2, c_lo, c_mid, c_hi;

    assign col_idx = cur_col[AW-1:0];
    assign up1     = lb1[col_idx];
    assign up2     = lb2[col_idx];
    assign c_lo    = min3(up2, up1, in_pix);
    assign c_mid   = med3(up2, up1, in_pix);
    assign c_hi    = max3(up2, up1, in_pix);

    // The window holds already column-sorted triples, so it doubles as the first pipeline stage.
    logic [PIX_W-1:0] win_lo [3];
    logic [PIX_W-1:0] win_mid [3];
    logic [PIX_W-1:0] win_hi [3];

    always_ff @(posedge clk) begin
        if (acc) begin
            lb1[col_idx] <= in_pix;
            lb2[col_idx] <= up1;
            win_lo[0]  <= win_lo[1];
            win_lo[1]  <= win_lo[2];
            win_lo[2]  <= c_lo;
            win_mid[0] <= win_mid[1];
            win_mid[1] <= win_mid[2];
            win_mid[2] <= c_mid;
            win_hi[0]  <= win_hi[1];
            win_hi[1]  <= win_hi[2];
            win_hi[2]  <= c_hi;
        end
    end

    logic             v1_q, eol1_q, last1_q;
    rank_t            rank1_q;
    logic             v2_q, eol2_q, last2_q;
    rank_t            rank2_q;
    logic [PIX_W-1:0] a2_q, b2_q, c2_q;
    logic [PIX_W-1:0] a2_d, b2_d, c2_d;

    always_comb begin
        a2_d = '0;
        b2_d = '0;
        c2_d = '0;
        case (rank1_q)
            RANK_MIN: a2_d = min3(win_lo[0], win_lo[1], win_lo[2]);
            RANK_MAX: a2_d = max3(win_hi[0], win_hi[1], win_hi[2]);
            default: begin
                a2_d = max3(win_lo[0], win_lo[1], win_lo[2]);
                b2_d = med3(win_mid[0], win_mid[1], win_mid[2]);
                c2_d = min3(win_hi[0], win_hi[1], win_hi[2]);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            rank_q    <= RANK_MED;
            sof_err   <= 1'b0;
            v1_q      <= 1'b0;
            eol1_q    <= 1'b0;
            last1_q   <= 1'b0;
            rank1_q   <= RANK_MED;
            v2_q      <= 1'b0;
            eol2_q    <= 1'b0;
            last2_q   <= 1'b0;
            rank2_q   <= RANK_MED;
            a2_q      <= '0;
            b2_q      <= '0;
            c2_q      <= '0;
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_eol   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            rank_q    <= rank_d;
            sof_err   <= sof_err_d;
            v1_q      <= acc && win_ok;
            eol1_q    <= eol_flag;
            last1_q   <= last_flag;
            rank1_q   <= cur_rank;
            v2_q      <= v1_q;
            eol2_q    <= eol1_q;
            last2_q   <= last1_q;
            rank2_q   <= rank1_q;
            a2_q      <= a2_d;
            b2_q      <= b2_d;
            c2_q      <= c2_d;
            out_valid <= v2_q;
            out_pix   <= (rank2_q == RANK_MED) ? med3(a2_q, b2_q, c2_q) : a2_q;
            out_eol   <= v2_q && eol2_q;
            done      <= v2_q && last2_q;
        end
    end
endmodule
